// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types for the two-port bus merge.
// FSM state, port index and port constants.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef logic port_t;

  localparam port_t PORT_IF  = 1'b0;
  localparam port_t PORT_LSU = 1'b1;

endpackage

// File: rtl/bus_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant, combinational.
// Lone requester wins; on a tie prio picks the winner.
module rr_arb2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt
);

  // one-hot grant, all zero when disabled
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio == PORT_LSU) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/bus_arb2.sv
// bus_arb2: merges fetch and load/store requests onto one bus.
// One transaction in flight; response returns to its issuer.
module bus_arb2
  import bus_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          s_valid,
  input  logic          s_ready,
  output logic [AW-1:0] s_addr,
  output logic          s_we,
  output logic [DW-1:0] s_wdata,
  input  logic          s_rvalid,
  input  logic [DW-1:0] s_rdata
);

  state_t     state;
  state_t     state_nxt;
  port_t      prio;
  port_t      owner;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       idle;
  logic       hs;
  logic       resp;

  assign req  = {m1_valid, m0_valid};
  assign idle = (state == IDLE);

  rr_arb2 u_arb (
    .req  (req),
    .prio (prio),
    .en   (idle),
    .gnt  (gnt)
  );

  // a grant only exists in IDLE for a valid port,
  // so any grant bit is a handshake
  assign m0_ready = gnt[0];
  assign m1_ready = gnt[1];
  assign hs       = |gnt;

  // s_valid follows state so reset drops it at once
  assign s_valid = (state == ISSUE);

  // s_rvalid outside WAIT is ignored
  assign resp = (state == WAIT) && s_rvalid;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs)       state_nxt = ISSUE;
      ISSUE:   if (s_ready)  state_nxt = WAIT;
      WAIT:    if (s_rvalid) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // capture the winning request and remember its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_addr  <= '0;
      s_we    <= 1'b0;
      s_wdata <= '0;
      owner   <= PORT_IF;
    end else if (hs) begin
      s_addr  <= gnt[1] ? m1_addr  : m0_addr;
      s_we    <= gnt[1] ? m1_we    : m0_we;
      s_wdata <= gnt[1] ? m1_wdata : m0_wdata;
      owner   <= gnt[1] ? PORT_LSU : PORT_IF;
    end
  end

  // serve the other port first next time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    prio <= PORT_IF;
    else if (resp) prio <= ~owner;
  end

  // route the response to its owner as a one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= resp && (owner == PORT_IF);
      m1_rvalid <= resp && (owner == PORT_LSU);
      if (resp && owner == PORT_IF)  m0_rdata <= s_rdata;
      if (resp && owner == PORT_LSU) m1_rdata <= s_rdata;
    end
  end

endmodule

// File: tb/tb_bus_arb2.sv
// tb_bus_arb2: directed and random checks of bus_arb2
// against a transaction-level model.
module tb_bus_arb2;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_valid, m0_ready, m0_we, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_valid, m1_ready, m1_we, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          s_valid, s_ready, s_we, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;

  always #5 clk = ~clk;

  bus_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready),
    .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_we(s_we),
    .s_wdata(s_wdata), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: one outstanding transaction, last-served fairness
  bit            busy, sent, own, prio;
  logic [AW-1:0] cap_addr;
  bit            cap_we;
  logic [DW-1:0] cap_wdata;
  bit   [1:0]    rv;
  logic [DW-1:0] rd [2];
  int            grant_log[$];

  // stimulus controls
  int            ready_mode, resp_mode;
  bit            resp_rand, rand_req;
  bit   [1:0]    rereq;
  logic [DW-1:0] resp_data;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] exp_gnt();
    if (busy) return 2'b00;
    if (m0_valid && m1_valid) return prio ? 2'b10 : 2'b01;
    return {m1_valid, m0_valid};
  endfunction

  task automatic model_reset();
    busy = 0; sent = 0; own = 0; prio = 0;
    cap_addr = '0; cap_we = 0; cap_wdata = '0;
    rv = 2'b00; rd[0] = '0; rd[1] = '0;
  endtask

  task automatic set_req(int p, logic [AW-1:0] a, bit w, logic [DW-1:0] d);
    if (p == 0) begin
      m0_valid = 1; m0_addr = a; m0_we = w; m0_wdata = d;
    end else begin
      m1_valid = 1; m1_addr = a; m1_we = w; m1_wdata = d;
    end
  endtask

  task automatic new_req(int p);
    set_req(p, $urandom, 1'($urandom_range(0, 1)), $urandom);
  endtask

  // compare every output against the model, away from the edge
  task automatic sample();
    bit [1:0] g;
    @(negedge clk);
    g = exp_gnt();
    chk("m0_ready", m0_ready, g[0]);
    chk("m1_ready", m1_ready, g[1]);
    chk("one_ready", m0_ready & m1_ready, 0);
    chk("s_valid", s_valid, busy && !sent);
    chk("s_addr", s_addr, cap_addr);
    chk("s_we", s_we, cap_we);
    chk("s_wdata", s_wdata, cap_wdata);
    chk("m0_rvalid", m0_rvalid, rv[0]);
    chk("m1_rvalid", m1_rvalid, rv[1]);
    chk("m0_rdata", m0_rdata, rd[0]);
    chk("m1_rdata", m1_rdata, rd[1]);
  endtask

  task automatic drive_stim(bit [1:0] acc);
    if (acc[0]) begin
      if (rereq[0]) new_req(0); else m0_valid = 0;
    end
    if (acc[1]) begin
      if (rereq[1]) new_req(1); else m1_valid = 0;
    end
    if (rand_req) begin
      if (!m0_valid && $urandom_range(0, 2) == 0) new_req(0);
      if (!m1_valid && $urandom_range(0, 2) == 0) new_req(1);
    end
    case (ready_mode)
      0:       s_ready = 0;
      1:       s_ready = 1;
      default: s_ready = 1'($urandom_range(0, 1));
    endcase
    case (resp_mode)
      0: s_rvalid = 0;
      1: s_rvalid = busy && sent;
      2: s_rvalid = (busy && sent) ? 1'($urandom_range(0, 1))
                                   : ($urandom_range(0, 15) == 0);
      default: s_rvalid = 1;
    endcase
    s_rdata = resp_rand ? DW'($urandom) : resp_data;
  endtask

  // advance the model across one rising edge
  task automatic tick();
    bit [1:0]      g, nrv, nacc;
    bit            nb, ns, no, np, nw;
    logic [AW-1:0] na;
    logic [DW-1:0] nd, nrd0, nrd1;
    g = exp_gnt();
    nb = busy; ns = sent; no = own; np = prio;
    na = cap_addr; nw = cap_we; nd = cap_wdata;
    nrd0 = rd[0]; nrd1 = rd[1];
    nrv = 2'b00; nacc = 2'b00;
    if (!busy && g != 2'b00) begin
      nb = 1; ns = 0; no = g[1]; nacc = g;
      na = g[1] ? m1_addr : m0_addr;
      nw = g[1] ? m1_we : m0_we;
      nd = g[1] ? m1_wdata : m0_wdata;
    end else if (busy && !sent && s_ready) begin
      ns = 1;
    end else if (busy && sent && s_rvalid) begin
      nb = 0; np = !own;
      nrv[own] = 1;
      if (own) nrd1 = s_rdata; else nrd0 = s_rdata;
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      nacc = 2'b00;
    end else begin
      busy = nb; sent = ns; own = no; prio = np;
      cap_addr = na; cap_we = nw; cap_wdata = nd;
      rv = nrv; rd[0] = nrd0; rd[1] = nrd1;
    end
    #1;
    if (nacc[0]) grant_log.push_back(0);
    if (nacc[1]) grant_log.push_back(1);
    drive_stim(nacc);
  endtask

  task automatic run(int n);
    repeat (n) begin
      sample();
      tick();
    end
  endtask

  task automatic clear_inputs();
    m0_valid = 0; m0_addr = '0; m0_we = 0; m0_wdata = '0;
    m1_valid = 0; m1_addr = '0; m1_we = 0; m1_wdata = '0;
    s_ready = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    rereq = 2'b00; rand_req = 0;
    ready_mode = 0; resp_mode = 0;
    model_reset();
    run(3);
    rst_n = 1;
  endtask

  initial begin
    int cnt;
    clear_inputs();
    model_reset();
    resp_rand = 0; resp_data = '0;
    do_reset();

    // single read from port 0
    ready_mode = 1; resp_mode = 1;
    resp_data = 32'hDEADBEEF;
    s_ready = 1;
    set_req(0, 32'h100, 0, 0);
    sample();
    chk("t1_m0_ready", m0_ready, 1);
    tick();
    sample();
    chk("t1_s_valid", s_valid, 1);
    chk("t1_s_addr", s_addr, 32'h100);
    chk("t1_s_we", s_we, 0);
    tick();
    run(1);
    sample();
    chk("t1_m0_rvalid", m0_rvalid, 1);
    chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    tick();
    sample();
    chk("t1_pulse_end", m0_rvalid, 0);
    tick();

    // both ports contend from reset
    do_reset();
    ready_mode = 1; resp_mode = 1; resp_rand = 1;
    s_ready = 1;
    rereq = 2'b11;
    grant_log.delete();
    new_req(0);
    new_req(1);
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) run(1);
    chk("t2_grants", grant_log.size(), 4);
    if (grant_log.size() >= 4)
      for (int k = 0; k < 4; k++)
        chk("t2_order", grant_log[k], k % 2);
    rereq = 2'b00;
    m0_valid = 0; m1_valid = 0;
    run(8);

    // port 1 write with a stalled downstream
    resp_rand = 0; resp_data = 32'h0BADF00D;
    ready_mode = 0; s_ready = 0;
    set_req(1, 32'h2000, 1, 32'h12345678);
    sample();
    chk("t3_m1_ready", m1_ready, 1);
    tick();
    repeat (5) begin
      sample();
      chk("t3_s_valid", s_valid, 1);
      chk("t3_s_addr", s_addr, 32'h2000);
      chk("t3_s_wdata", s_wdata, 32'h12345678);
      chk("t3_s_we", s_we, 1);
      tick();
    end
    ready_mode = 1; s_ready = 1;
    cnt = 0;
    repeat (6) begin
      sample();
      cnt += int'(m1_rvalid);
      tick();
    end
    chk("t3_m1_pulses", cnt, 1);

    // stray s_rvalid in IDLE and ISSUE
    resp_data = 32'hCAFE0001;
    resp_mode = 3; s_rvalid = 1;
    ready_mode = 0; s_ready = 0;
    cnt = 0;
    repeat (3) begin
      sample();
      cnt += int'(m0_rvalid) + int'(m1_rvalid);
      tick();
    end
    set_req(0, 32'h300, 0, 0);
    repeat (4) begin
      sample();
      cnt += int'(m0_rvalid) + int'(m1_rvalid);
      tick();
    end
    chk("t4_stray", cnt, 0);
    chk("t4_held", s_valid, 1);
    ready_mode = 1; s_ready = 1;
    cnt = 0;
    repeat (5) begin
      sample();
      cnt += int'(m0_rvalid);
      tick();
    end
    chk("t4_m0_pulses", cnt, 1);
    chk("t4_m0_rdata", m0_rdata, 32'hCAFE0001);
    resp_mode = 1; s_rvalid = 0;
    run(2);

    // reset while waiting for a response
    ready_mode = 1; resp_mode = 0; s_ready = 1;
    set_req(1, 32'h500, 0, 0);
    run(2);
    sample();
    chk("t5_in_wait", s_valid, 0);
    tick();
    rst_n = 0;
    clear_inputs();
    model_reset();
    sample();
    chk("t5_rst_s_valid", s_valid, 0);
    chk("t5_rst_s_addr", s_addr, 0);
    chk("t5_rst_m1_rdata", m1_rdata, 0);
    chk("t5_rst_m0_rdata", m0_rdata, 0);
    tick();
    rst_n = 1;
    resp_mode = 3; s_rvalid = 1;
    cnt = 0;
    repeat (3) begin
      sample();
      cnt += int'(m0_rvalid) + int'(m1_rvalid);
      tick();
    end
    chk("t5_stale", cnt, 0);
    resp_mode = 1; s_rvalid = 0;
    set_req(0, 32'h600, 0, 0);
    set_req(1, 32'h700, 0, 0);
    sample();
    chk("t5_m0_ready", m0_ready, 1);
    chk("t5_m1_ready", m1_ready, 0);
    tick();
    m1_valid = 0;
    run(8);

    // request fields sampled only at the handshake
    ready_mode = 0; s_ready = 0;
    set_req(0, 32'h40, 0, 0);
    run(1);
    m0_addr = 32'h80;
    repeat (3) begin
      sample();
      chk("t6_s_addr", s_addr, 32'h40);
      tick();
    end
    ready_mode = 1; s_ready = 1;
    run(6);

    // random traffic, with one reset in the middle
    rand_req = 1; ready_mode = 2; resp_mode = 2;
    resp_rand = 1;
    run(1500);
    do_reset();
    rand_req = 1; ready_mode = 2; resp_mode = 2;
    run(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
